// File: rtl/acc_serializer.sv
// Snapshots NU_COUNT MAC accumulators on update and streams them out one narrowed word per handshake.
// Optional saturation of the narrowed words is enabled by defining ACC_SERIALIZER_SAT_EN.
module acc_serializer #(
    parameter int unsigned NU_COUNT   = 16,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 8,
    localparam int unsigned LW = $clog2(NU_COUNT + 1),
    localparam int unsigned IW = $clog2(NU_COUNT)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          update,
    input  logic [LW-1:0]                 update_length,
    input  logic [NU_COUNT*ACC_WIDTH-1:0] acc_data,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [IW-1:0]                 out_index,
    output logic                          out_last,
    output logic                          busy,
    output logic                          drop,
    output logic                          sat_flag
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e                 state_q;
    logic [LW-1:0]          rem_q;
    logic [ACC_WIDTH-1:0]   cap_q [NU_COUNT];
    logic [LW-1:0]          len_eff;
    logic [IW-1:0]          idx_nxt;
    logic [DATA_WIDTH-1:0]  word_first;
    logic [DATA_WIDTH-1:0]  word_nxt;
    logic                   handshake;

`ifdef ACC_SERIALIZER_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SatMax = (ACC_WIDTH'(1) <<< (DATA_WIDTH - 1)) - 1;
    localparam logic signed [ACC_WIDTH-1:0] SatMin = -SatMax - 1;

    function automatic logic is_sat(input logic signed [ACC_WIDTH-1:0] x);
        logic signed [ACC_WIDTH-1:0] y;
        y = x >>> FRAC_BITS;
        return (y > SatMax) || (y < SatMin);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] narrow(input logic signed [ACC_WIDTH-1:0] x);
        logic signed [ACC_WIDTH-1:0] y;
        y = x >>> FRAC_BITS;
        if (y > SatMax) return DATA_WIDTH'(SatMax);
        if (y < SatMin) return DATA_WIDTH'(SatMin);
        return DATA_WIDTH'(y);
    endfunction
`else
    function automatic logic [DATA_WIDTH-1:0] narrow(input logic signed [ACC_WIDTH-1:0] x);
        return DATA_WIDTH'(x >>> FRAC_BITS);
    endfunction
`endif

    always_comb begin
        len_eff = update_length;
        if (update_length == '0 || update_length > LW'(NU_COUNT)) len_eff = LW'(NU_COUNT);
        idx_nxt    = out_index + 1'b1;
        word_first = narrow(acc_data[ACC_WIDTH-1:0]);
        word_nxt   = narrow(cap_q[idx_nxt]);
        handshake  = out_valid && out_ready;
    end

    // Capture storage carries no reset; its contents only matter while a snapshot is live.
    always_ff @(posedge clk) begin
        if (update) begin
            for (int i = 0; i < int'(NU_COUNT); i++) begin
                cap_q[i] <= acc_data[i*ACC_WIDTH +: ACC_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            drop      <= 1'b0;
        end else begin
            drop <= 1'b0;
            if (update) begin
                // An update coinciding with the final handshake is a clean hand-over, not an abort.
                drop      <= (state_q == StShift) && !(handshake && out_last);
                state_q   <= StShift;
                rem_q     <= len_eff;
                out_valid <= 1'b1;
                out_data  <= word_first;
                out_index <= '0;
                out_last  <= (len_eff == LW'(1));
            end else if (handshake) begin
                if (out_last) begin
                    state_q   <= StIdle;
                    rem_q     <= '0;
                    out_valid <= 1'b0;
                    out_data  <= '0;
                    out_index <= '0;
                    out_last  <= 1'b0;
                end else begin
                    rem_q     <= rem_q - 1'b1;
                    out_data  <= word_nxt;
                    out_index <= idx_nxt;
                    out_last  <= (rem_q == LW'(2));
                end
            end
        end
    end

    assign busy = out_valid;

`ifdef ACC_SERIALIZER_SAT_EN
    logic cur_sat_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_sat_q <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            if (update && state_q == StIdle) begin
                sat_flag <= 1'b0;
            end else if (handshake && cur_sat_q) begin
                sat_flag <= 1'b1;
            end
            if (update) begin
                cur_sat_q <= is_sat(acc_data[ACC_WIDTH-1:0]);
            end else if (handshake) begin
                cur_sat_q <= out_last ? 1'b0 : is_sat(cap_q[idx_nxt]);
            end
        end
    end
`else
    assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_acc_serializer.sv
// Directed self-checking bench for acc_serializer; inputs change and outputs are sampled 1ns after
// each rising edge.
module tb_acc_serializer;

    localparam int unsigned NU = 16;
    localparam int unsigned AW = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              update;
    logic [4:0]        update_length;
    logic [NU*AW-1:0]  acc_data;
    logic [15:0]       out_data;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_index;
    logic              out_last;
    logic              busy;
    logic              drop;
    logic              sat_flag;

    int tests  = 0;
    int failed = 0;

    acc_serializer dut (
        .clk          (clk),
        .reset        (reset),
        .update       (update),
        .update_length(update_length),
        .acc_data     (acc_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_index    (out_index),
        .out_last     (out_last),
        .busy         (busy),
        .drop         (drop),
        .sat_flag     (sat_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input int idx, input logic [15:0] data,
                            input logic last, input logic drp);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".busy"},  32'(busy),      32'd1);
        chk({tag, ".index"}, 32'(out_index), 32'(idx));
        chk({tag, ".data"},  32'(out_data),  32'(data));
        chk({tag, ".last"},  32'(out_last),  32'(last));
        chk({tag, ".drop"},  32'(drop),      32'(drp));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".busy"},  32'(busy),      32'd0);
        chk({tag, ".last"},  32'(out_last),  32'd0);
    endtask

    task automatic set_acc(input int base);
        for (int i = 0; i < int'(NU); i++) acc_data[i*AW +: AW] = 32'((base + i) << 8);
    endtask

    initial begin
        logic rdy_seq [5];
        int   idx_seq [5];
        rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        idx_seq = '{0, 1, 1, 1, 2};

        reset = 1'b0; update = 1'b0; update_length = '0; out_ready = 1'b0; acc_data = '0;
        #3;
        chk_idle("reset");
        chk("reset.data",  32'(out_data),  32'd0);
        chk("reset.index", 32'(out_index), 32'd0);
        chk("reset.drop",  32'(drop),      32'd0);
        chk("reset.sat",   32'(sat_flag),  32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Basic stream, len=0 means all 16; acc_data changes after capture must not leak in.
        set_acc(0); update_length = 5'd0; out_ready = 1'b1; update = 1'b1;
        tick();
        update = 1'b0; acc_data = '1;
        for (int i = 0; i < 16; i++) begin
            chk_word($sformatf("basic%0d", i), i, 16'(i), i == 15, 1'b0);
            tick();
        end
        chk_idle("basic.end");

        // Back-pressure, len=3 with ready 1,0,0,1,1.
        set_acc(100); update_length = 5'd3; update = 1'b1;
        tick();
        update = 1'b0;
        for (int c = 0; c < 5; c++) begin
            out_ready = rdy_seq[c];
            chk_word($sformatf("bp%0d", c), idx_seq[c], 16'(100 + idx_seq[c]), idx_seq[c] == 2,
                     1'b0);
            tick();
        end
        chk_idle("bp.end");
        out_ready = 1'b1;

        // Back-to-back: new update on the final handshake of a len=2 snapshot.
        set_acc(200); update_length = 5'd2; update = 1'b1;
        tick();
        update = 1'b0;
        chk_word("b2b.old0", 0, 16'd200, 1'b0, 1'b0);
        tick();
        chk_word("b2b.old1", 1, 16'd201, 1'b1, 1'b0);
        set_acc(300); update = 1'b1;
        tick();
        update = 1'b0;
        chk_word("b2b.new0", 0, 16'd300, 1'b0, 1'b0);
        tick();
        chk_word("b2b.new1", 1, 16'd301, 1'b1, 1'b0);
        tick();
        chk_idle("b2b.end");

        // Abort at index 1 of a len=8 snapshot.
        set_acc(400); update_length = 5'd8; update = 1'b1;
        tick();
        update = 1'b0;
        chk_word("abort.old0", 0, 16'd400, 1'b0, 1'b0);
        tick();
        chk_word("abort.old1", 1, 16'd401, 1'b0, 1'b0);
        set_acc(500); update_length = 5'd3; update = 1'b1;
        tick();
        update = 1'b0;
        chk_word("abort.new0", 0, 16'd500, 1'b0, 1'b1);
        tick();
        chk_word("abort.new1", 1, 16'd501, 1'b0, 1'b0);
        tick();
        chk_word("abort.new2", 2, 16'd502, 1'b1, 1'b0);
        tick();
        chk_idle("abort.end");

        // Length clamp: 20 behaves as 16.
        set_acc(600); update_length = 5'd20; update = 1'b1;
        tick();
        update = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk_word("clamp.last", 15, 16'd615, 1'b1, 1'b0);
        tick();
        chk_idle("clamp.end");

        // Narrowing corner values.
        acc_data = '0;
        acc_data[0*AW +: AW] = 32'h0100_0000;
        acc_data[1*AW +: AW] = 32'hFFFF_FFFF;
        acc_data[2*AW +: AW] = 32'h8000_0000;
        update_length = 5'd3; update = 1'b1;
        tick();
        update = 1'b0;
`ifdef ACC_SERIALIZER_SAT_EN
        chk_word("nar0", 0, 16'h7FFF, 1'b0, 1'b0); tick();
        chk_word("nar1", 1, 16'hFFFF, 1'b0, 1'b0); tick();
        chk_word("nar2", 2, 16'h8000, 1'b1, 1'b0); tick();
        chk("nar.sat", 32'(sat_flag), 32'd1);
`else
        chk_word("nar0", 0, 16'h0000, 1'b0, 1'b0); tick();
        chk_word("nar1", 1, 16'hFFFF, 1'b0, 1'b0); tick();
        chk_word("nar2", 2, 16'h0000, 1'b1, 1'b0); tick();
        chk("nar.sat", 32'(sat_flag), 32'd0);
`endif
        chk_idle("nar.end");
        set_acc(700); update_length = 5'd8; update = 1'b1;
        tick();
        update = 1'b0;
        chk("sat.clear", 32'(sat_flag), 32'd0);
        chk_word("rst.w0", 0, 16'd700, 1'b0, 1'b0);
        tick();

        // Abort, then asynchronous reset during the drop cycle.
        set_acc(800); update = 1'b1;
        tick();
        update = 1'b0;
        chk_word("rst.drop", 0, 16'd800, 1'b0, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk_idle("rst.async");
        chk("rst.async.index", 32'(out_index), 32'd0);
        chk("rst.async.drop",  32'(drop),      32'd0);
        #1 reset = 1'b1;
        tick();
        chk_idle("rst.release");
        set_acc(900); update_length = 5'd2; update = 1'b1;
        tick();
        update = 1'b0;
        chk_word("rst.restart0", 0, 16'd900, 1'b0, 1'b0);
        tick();
        chk_word("rst.restart1", 1, 16'd901, 1'b1, 1'b0);
        tick();
        chk_idle("rst.restart.end");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
